coin_timeout_return: RTL and testbench

COIN_TIMEOUT_RETURN -- requirements
Module: coin_timeout_return

---
 rtl/coin_timeout_return.sv | 150 +++++++++++++++
 tb/tb_coin_timeout_return.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/coin_timeout_return.sv
// Coin acceptor with purchase, overflow rejection and idle-timeout change return.
// IDLE handles purchase then coin credit; RETURN pays out the balance largest-coin first.
module coin_timeout_return #(
  parameter int NUM_COINS = 3,
  parameter int NUM_ITEMS = 4,
  parameter int BAL_W     = 16,
  parameter int TIMEOUT   = 100,
  parameter logic [NUM_COINS*BAL_W-1:0] COIN_VAL   = {16'd1000, 16'd500, 16'd100},
  parameter logic [NUM_ITEMS*BAL_W-1:0] ITEM_PRICE = {16'd2000, 16'd1000, 16'd500, 16'd400}
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_COINS-1:0] i_input_coin,
  input  logic [NUM_ITEMS-1:0] i_select_item,
  input  logic                 i_trigger_return,
  output logic [NUM_COINS-1:0] o_return_coin,
  output logic [NUM_COINS-1:0] o_reject_coin,
  output logic [NUM_ITEMS-1:0] o_output_item,
  output logic [NUM_ITEMS-1:0] o_available_item,
  output logic [BAL_W-1:0]     o_balance,
  output logic [31:0]          wait_time,
  output logic                 o_busy
);

  localparam logic [0:0]     ST_IDLE   = 1'b0;
  localparam logic [0:0]     ST_RETURN = 1'b1;
  localparam logic [31:0]    TIMEOUT_W = 32'(TIMEOUT);
  localparam logic [BAL_W:0] BAL_MAX   = {1'b0, {BAL_W{1'b1}}};

  logic [0:0]           state_r;
  logic [0:0]           state_nx_s;
  logic [BAL_W-1:0]     bal_nx_s;
  logic [31:0]          wait_nx_s;
  logic [31:0]          wait_dec_s;
  logic [NUM_COINS-1:0] ret_nx_s;
  logic [NUM_COINS-1:0] rej_nx_s;
  logic [NUM_ITEMS-1:0] item_nx_s;
  logic [NUM_ITEMS-1:0] avail_s;
  logic [BAL_W:0]       run_s;
  logic                 hit_s;
  logic                 credit_s;
  logic                 ret_go_s;

  function automatic logic [BAL_W-1:0] coin_val(input int idx);
    return COIN_VAL[idx*BAL_W +: BAL_W];
  endfunction

  function automatic logic [BAL_W-1:0] item_price(input int idx);
    return ITEM_PRICE[idx*BAL_W +: BAL_W];
  endfunction

  // Affordability of each item against the registered balance.
  always_comb begin
    avail_s = {NUM_ITEMS{1'b0}};
    for (int i = 0; i < NUM_ITEMS; i++) begin
      avail_s[i] = (item_price(i) <= o_balance);
    end
  end

  assign o_available_item = (state_r == ST_IDLE) ? avail_s : {NUM_ITEMS{1'b0}};
  assign o_busy           = (state_r == ST_RETURN);
  assign wait_dec_s       = (wait_time == 32'd0) ? 32'd0 : (wait_time - 32'd1);

  // Next-state, balance, timer and pulse outputs.
  always_comb begin
    state_nx_s = state_r;
    bal_nx_s   = o_balance;
    wait_nx_s  = wait_time;
    ret_nx_s   = {NUM_COINS{1'b0}};
    rej_nx_s   = {NUM_COINS{1'b0}};
    item_nx_s  = {NUM_ITEMS{1'b0}};
    run_s      = {1'b0, o_balance};
    hit_s      = 1'b0;
    credit_s   = 1'b0;
    ret_go_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        ret_go_s = ((wait_time == 32'd0) || i_trigger_return) && (o_balance != {BAL_W{1'b0}});
        if (ret_go_s) begin
          // Going to return wins over any purchase or credit this cycle.
          state_nx_s = ST_RETURN;
          rej_nx_s   = i_input_coin;
          wait_nx_s  = wait_dec_s;
        end else begin
          for (int i = 0; i < NUM_ITEMS; i++) begin
            if (!hit_s && i_select_item[i] && avail_s[i]) begin
              hit_s        = 1'b1;
              item_nx_s[i] = 1'b1;
              run_s        = run_s - {1'b0, item_price(i)};
            end else begin
              hit_s = hit_s;
            end
          end
          for (int i = 0; i < NUM_COINS; i++) begin
            if (i_input_coin[i] && ((run_s + {1'b0, coin_val(i)}) <= BAL_MAX)) begin
              run_s    = run_s + {1'b0, coin_val(i)};
              credit_s = 1'b1;
            end else begin
              rej_nx_s[i] = i_input_coin[i];
            end
          end
          bal_nx_s  = run_s[BAL_W-1:0];
          wait_nx_s = (hit_s || credit_s) ? TIMEOUT_W : wait_dec_s;
        end
      end
      ST_RETURN: begin
        rej_nx_s = i_input_coin;
        if (o_balance == {BAL_W{1'b0}}) begin
          state_nx_s = ST_IDLE;
          wait_nx_s  = TIMEOUT_W;
        end else if (o_balance < coin_val(0)) begin
          bal_nx_s = {BAL_W{1'b0}};
        end else begin
          for (int i = NUM_COINS - 1; i >= 0; i--) begin
            if (!hit_s && (coin_val(i) <= o_balance)) begin
              hit_s       = 1'b1;
              ret_nx_s[i] = 1'b1;
              bal_nx_s    = o_balance - coin_val(i);
            end else begin
              hit_s = hit_s;
            end
          end
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      o_balance     <= {BAL_W{1'b0}};
      wait_time     <= TIMEOUT_W;
      o_return_coin <= {NUM_COINS{1'b0}};
      o_reject_coin <= {NUM_COINS{1'b0}};
      o_output_item <= {NUM_ITEMS{1'b0}};
    end else begin
      state_r       <= state_nx_s;
      o_balance     <= bal_nx_s;
      wait_time     <= wait_nx_s;
      o_return_coin <= ret_nx_s;
      o_reject_coin <= rej_nx_s;
      o_output_item <= item_nx_s;
    end
  end

endmodule

// File: tb/tb_coin_timeout_return.sv
// Self-checking bench: directed scenarios plus a randomized run against an integer model.
module tb_coin_timeout_return;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  i_input_coin = 3'b000;
  logic [3:0]  i_select_item = 4'b0000;
  logic        i_trigger_return = 1'b0;
  logic [2:0]  o_return_coin, o_reject_coin;
  logic [3:0]  o_output_item, o_available_item;
  logic [15:0] o_balance;
  logic [31:0] wait_time;
  logic        o_busy;

  int n_cmp = 0;
  int n_fail = 0;

  int coin_v[3]  = '{100, 500, 1000};
  int price_v[4] = '{400, 500, 1000, 2000};
  localparam int MAXB = 65535;

  // Reference model state (what the DUT outputs should be after the last edge).
  bit       m_ret;
  int       m_bal, m_wait;
  bit [2:0] m_rc, m_rj;
  bit [3:0] m_oi;

  coin_timeout_return dut (
    .clk(clk), .reset(reset), .i_input_coin(i_input_coin), .i_select_item(i_select_item),
    .i_trigger_return(i_trigger_return), .o_return_coin(o_return_coin),
    .o_reject_coin(o_reject_coin), .o_output_item(o_output_item),
    .o_available_item(o_available_item), .o_balance(o_balance), .wait_time(wait_time),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  function automatic bit [3:0] m_avail();
    bit [3:0] a = 4'b0000;
    for (int i = 0; i < 4; i++) a[i] = !m_ret && (price_v[i] <= m_bal);
    return a;
  endfunction

  task automatic model_step(input bit [2:0] coin, input bit [3:0] sel, input bit trig, input bit rst);
    int b;
    bit got, cred;
    m_rc = 3'b000; m_rj = 3'b000; m_oi = 4'b0000;
    if (rst) begin
      m_ret = 1'b0; m_bal = 0; m_wait = 100;
    end else if (!m_ret) begin
      if ((m_wait == 0 || trig) && m_bal > 0) begin
        m_ret = 1'b1; m_rj = coin; m_wait = (m_wait > 0) ? m_wait - 1 : 0;
      end else begin
        b = m_bal; got = 1'b0; cred = 1'b0;
        for (int i = 0; i < 4; i++)
          if (!got && sel[i] && price_v[i] <= m_bal) begin got = 1'b1; m_oi[i] = 1'b1; b -= price_v[i]; end
        for (int i = 0; i < 3; i++)
          if (coin[i]) begin
            if (b + coin_v[i] <= MAXB) begin b += coin_v[i]; cred = 1'b1; end
            else m_rj[i] = 1'b1;
          end
        m_bal = b;
        m_wait = (got || cred) ? 100 : ((m_wait > 0) ? m_wait - 1 : 0);
      end
    end else begin
      m_rj = coin;
      if (m_bal == 0) begin
        m_ret = 1'b0; m_wait = 100;
      end else if (m_bal < coin_v[0]) begin
        m_bal = 0;
      end else begin
        got = 1'b0;
        for (int i = 2; i >= 0; i--)
          if (!got && coin_v[i] <= m_bal) begin got = 1'b1; m_rc[i] = 1'b1; m_bal -= coin_v[i]; end
      end
    end
  endtask

  task automatic tick(input bit [2:0] coin, input bit [3:0] sel, input bit trig, input bit rst);
    i_input_coin = coin; i_select_item = sel; i_trigger_return = trig; reset = rst;
    @(posedge clk);
    model_step(coin, sel, trig, rst);
    #1;
    i_input_coin = 3'b000; i_select_item = 4'b0000; i_trigger_return = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    tick(3'b000, 4'b0000, 1'b0, 1'b1);
    tick(3'b000, 4'b0000, 1'b0, 1'b1);
    n_cmp++; if (o_balance !== 16'd0) begin n_fail++; $display("FAIL reset_bal: got %0d want 0", o_balance); end
    n_cmp++; if (wait_time !== 32'd100) begin n_fail++; $display("FAIL reset_wait: got %0d want 100", wait_time); end
    n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    n_cmp++; if ({o_return_coin, o_reject_coin, o_output_item} !== 10'd0) begin n_fail++;
      $display("FAIL reset_pulses: got %b/%b/%b want zeros", o_return_coin, o_reject_coin, o_output_item); end
  endtask

  task automatic test_insert_purchase();
    tick(3'b010, 4'b0000, 1'b0, 1'b0);
    n_cmp++; if (wait_time !== 32'd100) begin n_fail++; $display("FAIL ins1_wait: got %0d want 100", wait_time); end
    tick(3'b000, 4'b0000, 1'b0, 1'b0);
    tick(3'b001, 4'b0000, 1'b0, 1'b0);
    n_cmp++; if (o_balance !== 16'd600) begin n_fail++; $display("FAIL ins_bal: got %0d want 600", o_balance); end
    n_cmp++; if (o_available_item !== 4'b0011) begin n_fail++; $display("FAIL ins_avail: got %b want 0011", o_available_item); end
    n_cmp++; if (wait_time !== 32'd100) begin n_fail++; $display("FAIL ins2_wait: got %0d want 100", wait_time); end
    tick(3'b000, 4'b0011, 1'b0, 1'b0);
    n_cmp++; if (o_output_item !== 4'b0001) begin n_fail++; $display("FAIL buy_item: got %b want 0001", o_output_item); end
    n_cmp++; if (o_balance !== 16'd200) begin n_fail++; $display("FAIL buy_bal: got %0d want 200", o_balance); end
    tick(3'b000, 4'b0000, 1'b0, 1'b0);
    n_cmp++; if (o_output_item !== 4'b0000) begin n_fail++; $display("FAIL buy_pulse: got %b want 0000", o_output_item); end
  endtask

  task automatic test_timeout_return();
    bit [2:0] want_rc[3] = '{3'b100, 3'b010, 3'b001};
    tick(3'b000, 4'b0000, 1'b0, 1'b1);
    tick(3'b100, 4'b0000, 1'b0, 1'b0);
    tick(3'b010, 4'b0000, 1'b0, 1'b0);
    tick(3'b001, 4'b0000, 1'b0, 1'b0);
    n_cmp++; if (o_balance !== 16'd1600) begin n_fail++; $display("FAIL to_bal: got %0d want 1600", o_balance); end
    for (int k = 0; k < 100; k++) tick(3'b000, 4'b0000, 1'b0, 1'b0);
    n_cmp++; if (wait_time !== 32'd0 || o_busy !== 1'b0) begin n_fail++;
      $display("FAIL to_expire: got wait %0d busy %b want 0/0", wait_time, o_busy); end
    tick(3'b000, 4'b0000, 1'b0, 1'b0);
    n_cmp++; if (o_busy !== 1'b1 || o_return_coin !== 3'b000) begin n_fail++;
      $display("FAIL to_enter: got busy %b coin %b want 1/000", o_busy, o_return_coin); end
    for (int k = 0; k < 3; k++) begin
      tick(3'b000, 4'b0000, 1'b0, 1'b0);
      n_cmp++; if (o_return_coin !== want_rc[k]) begin n_fail++;
        $display("FAIL to_coin%0d: got %b want %b", k, o_return_coin, want_rc[k]); end
    end
    n_cmp++; if (o_balance !== 16'd0) begin n_fail++; $display("FAIL to_drain: got %0d want 0", o_balance); end
    tick(3'b000, 4'b0000, 1'b0, 1'b0);
    n_cmp++; if (o_busy !== 1'b0 || wait_time !== 32'd100 || o_return_coin !== 3'b000) begin n_fail++;
      $display("FAIL to_exit: got busy %b wait %0d coin %b want 0/100/000", o_busy, wait_time, o_return_coin); end
  endtask

  task automatic test_overflow();
    tick(3'b000, 4'b0000, 1'b0, 1'b1);
    for (int k = 0; k < 65; k++) tick(3'b100, 4'b0000, 1'b0, 1'b0);
    tick(3'b011, 4'b0000, 1'b0, 1'b0);
    n_cmp++; if (o_balance !== 16'd65100 || o_reject_coin !== 3'b010) begin n_fail++;
      $display("FAIL ovf_partial: got bal %0d rej %b want 65100/010", o_balance, o_reject_coin); end
    for (int k = 0; k < 4; k++) tick(3'b001, 4'b0000, 1'b0, 1'b0);
    n_cmp++; if (o_balance !== 16'd65500) begin n_fail++; $display("FAIL ovf_fill: got %0d want 65500", o_balance); end
    tick(3'b001, 4'b0000, 1'b0, 1'b0);
    n_cmp++; if (o_balance !== 16'd65500 || o_reject_coin !== 3'b001) begin n_fail++;
      $display("FAIL ovf_reject: got bal %0d rej %b want 65500/001", o_balance, o_reject_coin); end
  endtask

  task automatic test_trigger_priority();
    tick(3'b000, 4'b0000, 1'b0, 1'b1);
    tick(3'b010, 4'b0000, 1'b0, 1'b0);
    tick(3'b001, 4'b0001, 1'b1, 1'b0);
    n_cmp++; if (o_output_item !== 4'b0000 || o_reject_coin !== 3'b001 || o_busy !== 1'b1 || o_balance !== 16'd500) begin
      n_fail++; $display("FAIL trig_prio: got item %b rej %b busy %b bal %0d want 0000/001/1/500",
        o_output_item, o_reject_coin, o_busy, o_balance); end
    tick(3'b100, 4'b0001, 1'b1, 1'b0);
    n_cmp++; if (o_return_coin !== 3'b010 || o_balance !== 16'd0 || o_reject_coin !== 3'b100) begin n_fail++;
      $display("FAIL trig_eject: got coin %b bal %0d rej %b want 010/0/100", o_return_coin, o_balance, o_reject_coin); end
  endtask

  task automatic test_reset_mid_return();
    tick(3'b000, 4'b0000, 1'b0, 1'b1);
    tick(3'b010, 4'b0000, 1'b0, 1'b0);
    tick(3'b001, 4'b0000, 1'b0, 1'b0);
    tick(3'b000, 4'b0000, 1'b1, 1'b0);
    tick(3'b000, 4'b0000, 1'b0, 1'b0);
    n_cmp++; if (o_return_coin !== 3'b010 || o_balance !== 16'd100) begin n_fail++;
      $display("FAIL rmr_first: got coin %b bal %0d want 010/100", o_return_coin, o_balance); end
    tick(3'b000, 4'b0000, 1'b0, 1'b1);
    n_cmp++; if (o_balance !== 16'd0 || o_busy !== 1'b0 || wait_time !== 32'd100 || o_return_coin !== 3'b000) begin
      n_fail++; $display("FAIL rmr_abort: got bal %0d busy %b wait %0d coin %b want 0/0/100/000",
        o_balance, o_busy, wait_time, o_return_coin); end
  endtask

  task automatic test_random();
    bit [2:0] c;
    bit [3:0] s;
    bit t, r;
    tick(3'b000, 4'b0000, 1'b0, 1'b1);
    for (int k = 0; k < 4000; k++) begin
      c = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      s = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      t = ($urandom_range(0, 40) == 0);
      r = ($urandom_range(0, 700) == 0);
      if ((k / 400) % 2 == 1 && k % 400 < 250) begin c = 3'b000; s = 4'b0000; t = 1'b0; end
      tick(c, s, t, r);
      n_cmp++; if (o_balance !== 16'(m_bal)) begin n_fail++; $display("FAIL rnd_bal@%0d: got %0d want %0d", k, o_balance, m_bal); end
      n_cmp++; if (wait_time !== 32'(m_wait)) begin n_fail++; $display("FAIL rnd_wait@%0d: got %0d want %0d", k, wait_time, m_wait); end
      n_cmp++; if (o_busy !== m_ret) begin n_fail++; $display("FAIL rnd_busy@%0d: got %b want %b", k, o_busy, m_ret); end
      n_cmp++; if (o_return_coin !== m_rc) begin n_fail++; $display("FAIL rnd_ret@%0d: got %b want %b", k, o_return_coin, m_rc); end
      n_cmp++; if (o_reject_coin !== m_rj) begin n_fail++; $display("FAIL rnd_rej@%0d: got %b want %b", k, o_reject_coin, m_rj); end
      n_cmp++; if (o_output_item !== m_oi) begin n_fail++; $display("FAIL rnd_item@%0d: got %b want %b", k, o_output_item, m_oi); end
      n_cmp++; if (o_available_item !== m_avail()) begin n_fail++;
        $display("FAIL rnd_avail@%0d: got %b want %b", k, o_available_item, m_avail()); end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_insert_purchase();
    test_timeout_return();
    test_overflow();
    test_trigger_priority();
    test_reset_mid_return();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
